// File: rtl/input_debounce_pkg.sv
// Shared types and constants for the input_debounce block.
// Glitch counters are built only with INPUT_DEBOUNCE_GLITCH_CNT_EN.
package input_debounce_pkg;

    typedef enum logic [0:0] {
        STABLE   = 1'b0,
        CHECKING = 1'b1
    } debounce_state_e;

    localparam int GLITCH_CNT_WIDTH = 8;

    localparam logic [GLITCH_CNT_WIDTH-1:0] GLITCH_CNT_MAX = 8'd255;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchronizer, hold-time FSM, optional glitch counter.
// Glitch counter present only with INPUT_DEBOUNCE_GLITCH_CNT_EN.
module debounce_channel
    import input_debounce_pkg::*;
#(
    parameter int       SYNC_STAGES = 2,
    parameter int       CNT_WIDTH   = 16,
    parameter logic     RESET_LEVEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] debounce_time,
    input  logic                 in,
    output logic                 out
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    ,
    input  logic                 glitch_clr,
    output logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt
`endif
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    debounce_state_e        state;
    logic [CNT_WIDTH-1:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // cnt saturates implicitly: >= compare stops it at debounce_time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE;
            cnt   <= '0;
            out   <= RESET_LEVEL;
        end else if (!enable) begin
            state <= STABLE;
            cnt   <= '0;
            out   <= s;
        end else begin
            unique case (state)
                STABLE: begin
                    if (s != out) begin
                        state <= CHECKING;
                        cnt   <= '0;
                    end
                end
                CHECKING: begin
                    if (s == out) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt >= debounce_time) begin
                        out   <= s;
                        state <= STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    logic glitch;

    assign glitch = enable && (state == CHECKING) && (s == out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch && (glitch_cnt != GLITCH_CNT_MAX)) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/input_debounce.sv
// Multi-channel input debouncer; one debounce_channel per input bit.
// Glitch counter ports present only with INPUT_DEBOUNCE_GLITCH_CNT_EN.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int   WIDTH       = 1,
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_WIDTH   = 16,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] debounce_time,
    input  logic [WIDTH-1:0]     in,
    output logic [WIDTH-1:0]     out
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    ,
    input  logic                 glitch_clr,
    output logic [WIDTH*GLITCH_CNT_WIDTH-1:0] glitch_cnt
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_WIDTH   (CNT_WIDTH),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .enable        (enable),
            .debounce_time (debounce_time),
            .in            (in[i]),
            .out           (out[i])
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
            ,
            .glitch_clr    (glitch_clr),
            .glitch_cnt    (glitch_cnt[i*GLITCH_CNT_WIDTH +: GLITCH_CNT_WIDTH])
`endif
        );
    end

endmodule
